// File: rtl/reg_file_port_master.sv
// Initiator-side sequencer for the 16x32 register file port: dumps every
// register out over a valid/ready stream, or loads every register from one.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; mode picks dump or load
// DUMP_RD | rfAddr = idx, register file read settles (bubble cycle)
// DUMP_TX | txValid high, word held until txReady
// LOAD_RX | rxReady high, waiting for rxValid
// LOAD_WR | rfWrtEn high for this one cycle, register file commits
// FINISH  | done pulse, busy still high
module reg_file_port_master #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rfAddr,
    input  logic [DW-1:0] rfData,
    output logic          rfWrtEn,
    output logic [AW-1:0] rfRd,
    output logic [DW-1:0] rfWrtData,
    output logic          txValid,
    output logic [DW-1:0] txData,
    output logic [AW-1:0] txIdx,
    input  logic          txReady,
    input  logic          rxValid,
    input  logic [DW-1:0] rxData,
    output logic          rxReady
);

    typedef enum logic [2:0] {
        IDLE,
        DUMP_RD,
        DUMP_TX,
        LOAD_RX,
        LOAD_WR,
        FINISH
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;

    // Read address is only meaningful while a dump word is being fetched.
    assign rfAddr = (state == DUMP_RD) ? idx : '0;

    // Sequencer with all handshake and register-file outputs registered.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rxReady   <= 1'b0;
            rfWrtEn   <= 1'b0;
            rfRd      <= '0;
            rfWrtData <= '0;
            txValid   <= 1'b0;
            txData    <= '0;
            txIdx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        if (mode) begin
                            state   <= LOAD_RX;
                            rxReady <= 1'b1;
                        end else begin
                            state <= DUMP_RD;
                        end
                    end
                end
                DUMP_RD: begin
                    txData  <= rfData;
                    txIdx   <= idx;
                    txValid <= 1'b1;
                    state   <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (txReady) begin
                        txValid <= 1'b0;
                        // Terminal compare comes first so idx never wraps.
                        if (idx == LAST) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DUMP_RD;
                        end
                    end
                end
                LOAD_RX: begin
                    if (rxValid) begin
                        rfWrtEn   <= 1'b1;
                        rfRd      <= idx;
                        rfWrtData <= rxData;
                        rxReady   <= 1'b0;
                        state     <= LOAD_WR;
                    end
                end
                LOAD_WR: begin
                    rfWrtEn <= 1'b0;
                    if (idx == LAST) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        idx     <= idx + 1'b1;
                        rxReady <= 1'b1;
                        state   <= LOAD_RX;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_file_port_master.md
Name: reg_file_port_master

Overview:
- Sequencer on the initiator side of the 16x32 register file read/write port.
- Dump mode: reads all 16 registers in index order over the rs1/out1 path and streams each word out through a valid/ready handshake.
- Load mode: accepts 16 words over a valid/ready handshake and writes them into registers 0..15 through the rd/wrtData/wrtEn path.
- Used for debug snapshot/restore. The processor is held by the core while busy is high.

Parameters:
- NREGS, 16, number of registers transferred per operation.
- AW, 4, register address width; log2(NREGS).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- res  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = dump, 1 = load; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- rfAddr  out  AW  drives register file rs1.
- rfData  in  DW  register file out1; combinational read of rfAddr.
- rfWrtEn  out  1  register file wrtEn.
- rfRd  out  AW  register file rd.
- rfWrtData  out  DW  register file wrtData.
- txValid  out  1  dump word valid.
- txData  out  DW  dump word.
- txIdx  out  AW  register index of txData.
- txReady  in  1  downstream accepts the dump word.
- rxValid  in  1  load word valid.
- rxData  in  DW  load word.
- rxReady  out  1  block accepts the load word.

Behaviour:
- Reset (res=1 at a posedge) overrides everything, including mid-operation.
  - State goes to IDLE and the index counter clears to 0.
  - All outputs go to 0: busy, done, txValid, txData, txIdx, rxReady, rfWrtEn, rfRd, rfWrtData, rfAddr.
  - A partially completed load is not rolled back.
- States: IDLE, DUMP_RD, DUMP_TX, LOAD_RX, LOAD_WR, FINISH.
- IDLE:
  - rfAddr=0.
  - On start=1, latch mode, clear idx=0, go to DUMP_RD (mode 0) or LOAD_RX (mode 1).
- DUMP_RD:
  - rfAddr=idx (combinational).
  - At the next edge, txData<=rfData, txIdx<=idx, txValid<=1, go to DUMP_TX.
- DUMP_TX:
  - txValid, txData and txIdx are held stable until txReady=1 at an edge.
  - On that handshake, txValid<=0.
  - If idx==NREGS-1, go to FINISH; else idx<=idx+1 and go to DUMP_RD.
- Dump timing:
  - start accepted at edge E0 gives txValid high after E1.
  - Minimum 2 cycles per word; bubble cycle in DUMP_RD.
  - If txReady is held high, 16 words take 32 cycles, plus FINISH.
- LOAD_RX:
  - rxReady=1.
  - On rxValid&rxReady at an edge: rfWrtEn<=1, rfRd<=idx, rfWrtData<=rxData, go to LOAD_WR.
- LOAD_WR:
  - rxReady=0; rfWrtEn is high for exactly this cycle, so the register file commits at the end of it.
  - Then rfWrtEn<=0.
  - If idx==NREGS-1, go to FINISH; else idx<=idx+1 and go to LOAD_RX.
- rxValid while rxReady=0 is ignored; the sender holds its word.
- FINISH:
  - done=1 for one cycle; busy stays 1.
  - Next edge goes to IDLE.
- start is ignored in every non-IDLE state, including FINISH. mode changes after acceptance are ignored.
- Register 0 is ordinary: it is read and written like all others.
- idx never wraps past NREGS-1; the terminal compare precedes any increment.
- rfWrtEn is never high outside LOAD_WR. txValid is never high outside DUMP_TX.

Test Plan:
- Reset then idle: hold res 2 cycles -> all outputs 0; start with res=1 -> ignored, busy stays 0.
- Dump, txReady held 1:
  - Preload reg[i]=0xA0000000+i, start, mode=0.
  - txValid first high 2 cycles after start.
  - 16 words, txIdx 0..15, data 0xA0000000..0xA000000F.
  - done pulses once; busy low 34 cycles after start.
- Dump with backpressure: txReady low 5 cycles on word 3 -> txData=0xA0000003 and txIdx=3 stable throughout; no word skipped or duplicated.
- Load:
  - Send 0x11111111*k for k=0..15, with rxValid gaps of 0–3 cycles.
  - Each word gives exactly one rfWrtEn pulse with rfRd=k.
  - A following dump returns the same 16 values.
- Start while busy: pulse start with mode=1 during a dump -> ignored; dump completes unchanged; done pulses once.
- Reset mid-load after 6 words -> next cycle busy=0, rfWrtEn=0, idx=0; a new start begins at register 0.
